// File: rtl/seq_pkg.sv
// Shared constants, state encoding and beat-vector slicing for the sequencer.
package seq_pkg;

    localparam int unsigned STEPS   = 16;
    localparam int unsigned PITCH_W = 3;
    localparam int unsigned BEAT_W  = STEPS * PITCH_W;
    localparam int unsigned STEP_W  = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } sched_state_t;

    // Pitch of step idx; step i lives at [i*PITCH_W +: PITCH_W].
    function automatic logic [PITCH_W-1:0] pitch_at(
        input logic [BEAT_W-1:0] beats,
        input logic [STEP_W-1:0] idx
    );
        return beats[int'(idx) * PITCH_W +: PITCH_W];
    endfunction

endpackage

// File: rtl/step_scheduler_step_timer.sv
// Tempo counter: counts while enabled, holds while not, wraps every period cycles.
module step_timer #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             wrap
);

    logic [DIV_W-1:0] tick_q;
    logic [DIV_W-1:0] tick_d;
    logic [DIV_W-1:0] last;

    // Zero period behaves as one; a count already past a shortened period wraps at once.
    always_comb begin
        last   = (period == '0) ? '0 : period - DIV_W'(1);
        wrap   = en && !clr && (tick_q >= last);
        tick_d = tick_q;
        if (clr || wrap) begin
            tick_d = '0;
        end else if (en) begin
            tick_d = tick_q + DIV_W'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/step_scheduler.sv
// Playback controller: walks the beat vector at a programmable tempo, emitting note strobes and gate.
module step_scheduler #(
    parameter int unsigned STEPS   = seq_pkg::STEPS,
    parameter int unsigned PITCH_W = seq_pkg::PITCH_W,
    parameter int unsigned DIV_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [STEPS*PITCH_W-1:0] beats,
    input  logic                     run,
    input  logic                     restart,
    input  logic [DIV_W-1:0]         step_period,
    input  logic [DIV_W-1:0]         gate_len,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic [PITCH_W-1:0]       pitch,
    output logic                     note_on,
    output logic                     gate,
    output logic                     bar_start,
    output logic                     playing
);

    import seq_pkg::*;

    localparam int unsigned IDX_W = $clog2(STEPS);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   step_idx_q, step_idx_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic               note_on_q, note_on_d;
    logic               gate_q, gate_d;
    logic               bar_start_q, bar_start_d;
    logic               playing_q, playing_d;
    logic [DIV_W-1:0]   gate_cnt_q, gate_cnt_d;

    logic               fire;
    logic [IDX_W-1:0]   target;
    logic [PITCH_W-1:0] fire_pitch;
    logic [DIV_W-1:0]   gate_last;
    logic               t_clr;
    logic               t_en;
    logic               wrap;

    // The resume cycle out of PAUSE already counts, so counting picks up where it stopped.
    assign t_clr     = restart || (state_q == IDLE);
    assign t_en      = run && (state_q != IDLE);
    assign gate_last = (gate_len == '0) ? '0 : gate_len - DIV_W'(1);

    step_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (t_clr),
        .en     (t_en),
        .period (step_period),
        .wrap   (wrap)
    );

    // Next-state, fire decision and gate countdown.
    always_comb begin
        state_d     = state_q;
        step_idx_d  = step_idx_q;
        pitch_d     = pitch_q;
        note_on_d   = 1'b0;
        bar_start_d = 1'b0;
        gate_d      = gate_q;
        gate_cnt_d  = gate_cnt_q;
        fire        = 1'b0;
        target      = step_idx_q + IDX_W'(1);

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    fire    = 1'b1;
                    target  = '0;
                    state_d = PLAY;
                end
            end
            PLAY, PAUSE: begin
                if (restart) begin
                    if (run) begin
                        fire    = 1'b1;
                        target  = '0;
                        state_d = PLAY;
                    end else begin
                        state_d    = IDLE;
                        step_idx_d = '0;
                        gate_d     = 1'b0;
                    end
                end else if (!run) begin
                    state_d = PAUSE;
                    gate_d  = 1'b0;
                end else begin
                    state_d = PLAY;
                    if (wrap) begin
                        fire = 1'b1;
                    end else if (gate_q) begin
                        if (gate_cnt_q == '0) begin
                            gate_d = 1'b0;
                        end else begin
                            gate_cnt_d = gate_cnt_q - DIV_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fire_pitch = pitch_at(beats, target);
        if (fire) begin
            step_idx_d  = target;
            pitch_d     = fire_pitch;
            note_on_d   = (fire_pitch != '0);
            bar_start_d = (target == '0);
            gate_d      = (fire_pitch != '0);
            if (fire_pitch != '0) begin
                gate_cnt_d = gate_last;
            end
        end

        playing_d = (state_d == PLAY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_idx_q  <= '0;
            pitch_q     <= '0;
            note_on_q   <= 1'b0;
            gate_q      <= 1'b0;
            bar_start_q <= 1'b0;
            playing_q   <= 1'b0;
            gate_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_idx_q  <= step_idx_d;
            pitch_q     <= pitch_d;
            note_on_q   <= note_on_d;
            gate_q      <= gate_d;
            bar_start_q <= bar_start_d;
            playing_q   <= playing_d;
            gate_cnt_q  <= gate_cnt_d;
        end
    end

    assign step_idx  = step_idx_q;
    assign pitch     = pitch_q;
    assign note_on   = note_on_q;
    assign gate      = gate_q;
    assign bar_start = bar_start_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler; expectations are hand-derived cycle counts.
module tb_step_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] beats;
    logic        run;
    logic        restart;
    logic [23:0] step_period;
    logic [23:0] gate_len;
    logic [3:0]  step_idx;
    logic [2:0]  pitch;
    logic        note_on;
    logic        gate;
    logic        bar_start;
    logic        playing;

    int checks   = 0;
    int failures = 0;

    step_scheduler #(
        .STEPS   (16),
        .PITCH_W (3),
        .DIV_W   (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .beats       (beats),
        .run         (run),
        .restart     (restart),
        .step_period (step_period),
        .gate_len    (gate_len),
        .step_idx    (step_idx),
        .pitch       (pitch),
        .note_on     (note_on),
        .gate        (gate),
        .bar_start   (bar_start),
        .playing     (playing)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, settling 1 ns past each.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until note_on is seen, -1 if the budget runs out.
    task automatic wait_note(input int max, output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int i = 1; i <= max; i++) begin
            if (!found) begin
                step(1);
                if (note_on === 1'b1) begin
                    found = 1'b1;
                    n = i;
                end
            end
        end
    endtask

    task automatic go_idle();
        run     = 1'b0;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    initial begin
        int n;
        int bars;
        int notes;
        int bad;
        int idx31;
        logic [3:0] prev;

        rst_n       = 1'b0;
        run         = 1'b0;
        restart     = 1'b0;
        beats       = '0;
        step_period = 24'd4;
        gate_len    = 24'd2;

        // Reset state
        step(2);
        check("rst_step_idx", step_idx, 0);
        check("rst_pitch", pitch, 0);
        check("rst_note_on", note_on, 0);
        check("rst_gate", gate, 0);
        check("rst_bar_start", bar_start, 0);
        check("rst_playing", playing, 0);
        rst_n = 1'b1;
        step(2);
        check("idle_playing", playing, 0);

        // Basic playback: step0=5, step1=rest, step2=3, period 4, gate 2
        beats[2:0] = 3'd5;
        beats[8:6] = 3'd3;
        run = 1'b1;
        step(1);
        check("t1_note_on", note_on, 1);
        check("t1_pitch", pitch, 5);
        check("t1_bar_start", bar_start, 1);
        check("t1_gate_a", gate, 1);
        check("t1_playing", playing, 1);
        step(1);
        check("t1_gate_b", gate, 1);
        check("t1_note_off", note_on, 0);
        step(1);
        check("t1_gate_end", gate, 0);
        step(2);
        check("t1_step1_idx", step_idx, 1);
        check("t1_step1_note", note_on, 0);
        check("t1_step1_gate", gate, 0);
        step(4);
        check("t1_step2_idx", step_idx, 2);
        check("t1_step2_pitch", pitch, 3);
        check("t1_step2_note", note_on, 1);

        // Full bar wrap: all steps pitch 1, period 2
        go_idle();
        check("t2_idle_idx", step_idx, 0);
        beats       = 48'h249249249249;
        step_period = 24'd2;
        gate_len    = 24'd1;
        run         = 1'b1;
        bars = 0; notes = 0; bad = 0; idx31 = -1;
        for (int i = 1; i <= 33; i++) begin
            step(1);
            if (bar_start === 1'b1) bars++;
            if (note_on === 1'b1) notes++;
            if (note_on !== ((i % 2) == 1)) bad++;
            if (i == 31) idx31 = int'(step_idx);
        end
        check("t2_bar_pulses", bars, 2);
        check("t2_note_count", notes, 17);
        check("t2_note_alternate", bad, 0);
        check("t2_idx_15", idx31, 15);
        check("t2_idx_wrap", step_idx, 0);

        // Pause at tick 2 of period 8, then resume
        go_idle();
        step_period = 24'd8;
        gate_len    = 24'd20;
        run         = 1'b1;
        step(1);
        check("t3_first_note", note_on, 1);
        step(2);
        check("t3_gate_before", gate, 1);
        run = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (gate !== 1'b0 || note_on !== 1'b0 || step_idx !== 4'd0 || playing !== 1'b0) bad++;
        end
        check("t3_paused_quiet", bad, 0);
        check("t3_paused_idx", step_idx, 0);
        run = 1'b1;
        wait_note(12, n);
        check("t3_resume_edges", n, 6);
        check("t3_resume_idx", step_idx, 1);

        // Restart with run=1 at step 9
        go_idle();
        step_period = 24'd4;
        gate_len    = 24'd2;
        run         = 1'b1;
        step(1);
        step(36);
        check("t4_at_step9", step_idx, 9);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("t4_restart_idx", step_idx, 0);
        check("t4_restart_bar", bar_start, 1);
        wait_note(8, n);
        check("t4_next_fire_edges", n, 4);
        check("t4_next_idx", step_idx, 1);

        // Legato: gate longer than step, then zero period
        beats    = 48'hFFFFFFFFFFFF;
        gate_len = 24'd10;
        restart  = 1'b1;
        step(1);
        restart  = 1'b0;
        check("t5_note", note_on, 1);
        check("t5_pitch", pitch, 7);
        notes = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (note_on === 1'b1) notes++;
            if (gate !== 1'b1) bad++;
        end
        check("t5_legato_notes", notes, 4);
        check("t5_legato_gate", bad, 0);
        check("t5_legato_idx", step_idx, 4);
        step_period = 24'd0;
        notes = 0; bad = 0;
        prev = step_idx;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (note_on === 1'b1) notes++;
            if (gate !== 1'b1) bad++;
            if (step_idx !== prev + 4'd1) bad++;
            prev = step_idx;
        end
        check("t5_zero_period_notes", notes, 8);
        check("t5_zero_period_bad", bad, 0);

        // Asynchronous reset mid-note, then replay from step 0
        check("t6_gate_before", gate, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_idx", step_idx, 0);
        check("t6_rst_pitch", pitch, 0);
        check("t6_rst_note", note_on, 0);
        check("t6_rst_gate", gate, 0);
        check("t6_rst_bar", bar_start, 0);
        check("t6_rst_playing", playing, 0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        step_period = 24'd4;
        step(1);
        check("t6_replay_idx", step_idx, 0);
        check("t6_replay_bar", bar_start, 1);
        check("t6_replay_note", note_on, 1);
        check("t6_replay_pitch", pitch, 7);
        check("t6_replay_playing", playing, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
Playback controller for the 16-step sequencer data model. It walks a step pointer through the packed 48-bit beat vector at a programmable tempo and latches the 3-bit pitch of each step as it fires. It produces a registered note_on strobe and a timed gate for the downstream tone generator. It has no write path into the model; editing remains the model's concern.

Parameters:
STEPS, 16, number of steps per bar (power of two)
PITCH_W, 3, bits per step in beats
DIV_W, 24, width of the tempo and gate counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
beats  in  STEPS*PITCH_W  packed pitch vector from the model; step i occupies [i*PITCH_W +: PITCH_W]
run  in  1  level: 1 = play, 0 = pause
restart  in  1  one-cycle pulse: return to step 0
step_period  in  DIV_W  clk cycles per step; 0 is treated as 1
gate_len  in  DIV_W  clk cycles the gate stays high per note; 0 is treated as 1
step_idx  out  $clog2(STEPS)  index of the most recently fired step
pitch  out  PITCH_W  pitch latched at the last fire
note_on  out  1  one-cycle strobe per fired non-rest step
gate  out  1  note sounding
bar_start  out  1  one-cycle strobe when step 0 fires
playing  out  1  high in PLAY

Behaviour:
- Reset (async assert, sync deassert by the user) drives: state=IDLE, step_idx=0, pitch=0, note_on=0, gate=0, bar_start=0, playing=0, tick_cnt=0, gate_cnt=0.
- States: IDLE, PLAY, PAUSE. All outputs are registered.
- fire is an internal single-cycle event. On fire, the block samples pitch from beats at the target step. One cycle later it registers step_idx, pitch, note_on = (pitch != 0), and bar_start = (target step == 0).
- IDLE -> PLAY when run=1. This fires step 0 and sets tick_cnt=0.
- PLAY: tick_cnt increments each cycle. When tick_cnt == eff_period-1, the block fires step (step_idx+1) mod STEPS and sets tick_cnt=0. Step 15 wraps to step 0, which asserts bar_start.
- The step rate in steady state is exactly one fire per eff_period cycles. With eff_period=1, every cycle fires and note_on may stay high continuously.
- PLAY -> PAUSE when run=0. tick_cnt and step_idx hold, gate clears the next cycle, and no fire occurs.
- PAUSE -> PLAY when run=1. Counting resumes from the held tick_cnt. The current step does not re-fire.
- restart has priority over run transitions.
  - With run=1: step_idx target=0, tick_cnt=0, step 0 fires, state=PLAY.
  - With run=0: state=IDLE, step_idx=0, gate=0, no fire.
- Gate:
  - On a fire of a non-rest step, gate=1 and gate_cnt is loaded with eff_gate-1. gate_cnt decrements each PLAY cycle, and gate clears when it reaches 0 with no new fire.
  - A fire of a rest step (pitch 0) clears gate.
  - A non-rest fire while gate=1 retriggers (reloads gate_cnt); gate stays high and note_on still pulses. This gives legato when gate_len >= step_period.
- Edits to beats mid-step do not change pitch until the next fire.
- step_period or gate_len changes take effect at the next comparison and reload. Do not clip tick_cnt: if tick_cnt >= new eff_period-1, fire on the next cycle.
- playing = (state == PLAY), registered.
- Asserting rst_n low mid-play clears all outputs immediately.

Decomposition:
- Shared package seq_pkg holds:
  - STEPS, PITCH_W, BEAT_W = STEPS*PITCH_W, STEP_W = $clog2(STEPS).
  - typedef enum sched_state_t {IDLE, PLAY, PAUSE}.
  - function pitch_at(beats, idx) for slice extraction. The data model reuses the same constants.
- One sub-module, step_timer: the tempo counter with clear/hold/enable inputs, producing the wrap strobe and handling the zero-period clamp. The FSM and gate logic stay in step_scheduler.

Test Plan:
- beats step0=5, step1=0, step2=3; step_period=4; gate_len=2; run rises at cycle T.
  - note_on at T+1 with pitch=5 and bar_start=1; gate high T+1..T+2.
  - Step 1 at T+5: note_on=0, gate=0.
  - Step 2 at T+9: pitch=3, note_on=1.
- All steps=1, step_period=2: after 32 cycles, step_idx wraps 15 -> 0; bar_start pulses exactly twice; note_on is high every other cycle.
- Pause/resume: run drops mid-step at tick_cnt=2 of period 8.
  - gate=0, step_idx holds, no note_on for 20 cycles.
  - After run rises, the next fire occurs 5 cycles later.
- restart with run=1 at step 9: step_idx=0, bar_start=1 the next cycle, tick_cnt=0; the following fire is step 1 after step_period cycles.
- gate_len=10, step_period=4, all steps=7: gate stays high continuously while note_on pulses every 4 cycles. Setting step_period=0 yields a fire every cycle.
- Assert rst_n low mid-note: all outputs are 0 in the same cycle. After release with run=1, play restarts at step 0.
